fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational fp_adder (in1, in2, out; IEEE-754 single precision) between two requesters.
- Each requester issues operands over a valid/ready handshake and receives its sum over a separate valid/ready response channel.
- Operands are registered before the adder and the sum is registered after it; the adder is treated as a multicycle path of SETTLE_CYCLES cycles.
- Sits between the FPU front-end clients and the shared fp_adder instance, which this block instantiates internally.

Parameters:
- SETTLE_CYCLES, 2, cycles the registered operands are held on the adder before the result is captured; legal range 1..15.

Ports:
- clk  in  1  system clock; single clock domain, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a  in  32  requester 0 operand A
- req0_b  in  32  requester 0 operand B
- req1_valid, req1_ready, req1_a, req1_b  as for requester 0
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes the result
- rsp0_data  out  32  sum for requester 0
- rsp1_valid, rsp1_ready, rsp1_data  as for requester 0
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: state=IDLE, prio=0, operand/result registers=0, all req*_ready=0, all rsp*_valid=0, rsp*_data=0, busy=0.
- Reset mid-operation abandons the transaction; no response is issued.
- Grant logic:
  - In IDLE only, grant g is computed combinationally from req0_valid, req1_valid and prio.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester indicated by prio wins.
- Ready: req{g}_ready=1 in that IDLE cycle only. Ready is never asserted outside IDLE, and never when the corresponding valid is 0.
- Accept edge:
  - Capture a_q<=req{g}_a, b_q<=req{g}_b, owner<=g.
  - Load cnt<=SETTLE_CYCLES-1.
  - Go to WAIT.
- WAIT:
  - fp_adder.in1=a_q, fp_adder.in2=b_q.
  - If cnt==0: res_q<=fp_adder.out, go to RESP. Otherwise decrement cnt.
  - WAIT lasts exactly SETTLE_CYCLES cycles.
- RESP:
  - rsp{owner}_valid=1 and rsp{owner}_data=res_q; the other rsp channel stays invalid.
  - Data holds stable while valid is high.
  - On the edge where rsp{owner}_ready=1: prio<=~owner, go to IDLE.
  - Backpressure (ready=0) holds RESP indefinitely; new requests wait.
- Latency: rsp_valid rises SETTLE_CYCLES+1 cycles after the accept cycle.
- Throughput: one operation per SETTLE_CYCLES+2 cycles minimum (IDLE, WAIT, RESP with immediate ready).
- rsp*_data is 0 when its valid is low.
- Requester operands may change after acceptance without affecting the result.
- A requester that drops valid before being granted is not served; no ready is issued to it.

Optional Feature:
- Macro: FP_ADD_ARBITER_SUB_EN.
- When defined:
  - Adds ports req0_op and req1_op (in, 1 bit each); 1 = subtract.
  - op is captured with the operands.
  - In WAIT, fp_adder.in2 = {b_q[31]^op_q, b_q[30:0]}, giving A-B.
- When undefined: the op ports do not exist and the block always adds.

Test Plan:
- Single op: after reset, req0 A=0x3F800000 (1.0), B=0x40000000 (2.0), SETTLE_CYCLES=2 -> req0_ready for one cycle; rsp0_valid 3 cycles later with data 0x40400000 (3.0); rsp1_valid stays 0.
- Simultaneous contention: both valid after reset, req0 0.5+0.25 (0x3F000000, 0x3E800000), req1 1.0+2.0 -> req0 served first with 0x3F400000; then req1 with 0x40400000; prio toggles to 0 afterwards.
- Fairness: both requesters hold valid continuously for 4 ops -> grants alternate 0,1,0,1; each response matches its own operands.
- Backpressure: rsp0_ready held 0 for 5 cycles during RESP -> rsp0_valid and rsp0_data stable; req1_ready stays 0 until the RESP handshake completes.
- Reset mid-WAIT: rst asserted during WAIT -> next cycle busy=0, no rsp_valid; a subsequent request completes normally.
- With FP_ADD_ARBITER_SUB_EN: req1 op=1, A=0x40400000 (3.0), B=0x3F800000 (1.0) -> rsp1_data=0x40000000 (2.0); op=0 with the same operands -> 0x40800000 (4.0).

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one combinational single-precision adder between two requesters.
// Define FP_ADD_ARBITER_SUB_EN to add per-requester op inputs (1 = A-B).

module fp_adder (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out
);
  logic [31:0]       big, sml;
  logic [7:0]        eb, es, d;
  logic [23:0]       mb, ms;
  logic [49:0]       sh;
  logic [26:0]       ms_x, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic              found, rnd;
  logic [24:0]       mr;
  logic signed [9:0] exp_n;

  always_comb begin
    big = in2;
    sml = in1;
    if (in1[30:0] >= in2[30:0]) begin
      big = in1;
      sml = in2;
    end
    eb = big[30:23];
    es = sml[30:23];
    // Denormal inputs are flushed to zero.
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
    ms = (es == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
    d  = eb - es;
    sh = {ms, 26'b0} >> d;
    if (d > 8'd26) ms_x = {26'b0, |ms};
    else           ms_x = {sh[49:24], |sh[23:0]};
    if (big[31] ^ sml[31]) sum = {1'b0, mb, 3'b0} - {1'b0, ms_x};
    else                   sum = {1'b0, mb, 3'b0} + {1'b0, ms_x};
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(27 - i);
        found = 1'b1;
      end
    end
    if (sum[27]) norm = {sum[27:2], sum[1] | sum[0]};
    else         norm = sum[26:0] << (lz - 5'd1);
    exp_n = $signed({2'b0, eb}) + 10'sd1 - $signed({5'b0, lz});
    // Round to nearest, ties to even, on guard/round/sticky.
    rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr  = {1'b0, norm[26:3]} + {24'b0, rnd};
    if (mr[24]) begin
      mr    = {1'b0, mr[24:1]};
      exp_n = exp_n + 10'sd1;
    end
    out = {big[31], exp_n[7:0], mr[22:0]};
    if (sum == 28'd0)            out = 32'd0;
    else if (exp_n >= 10'sd255)  out = {big[31], 8'hFF, 23'b0};
    else if (exp_n <= 10'sd0)    out = {big[31], 31'b0};
    if (eb == 8'hFF) begin
      if (big[22:0] != 23'd0 || ((big[31] ^ sml[31]) && es == 8'hFF)) out = 32'h7FC00000;
      else out = big;
    end
  end
endmodule

module fp_add_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FP_ADD_ARBITER_SUB_EN
  input  logic        req0_op,
  input  logic        req1_op,
`endif
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d, owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [31:0] add_in2, add_out;
  logic        grant, idle;

`ifdef FP_ADD_ARBITER_SUB_EN
  logic op_q, op_d;
  assign add_in2 = {b_q[31] ^ op_q, b_q[30:0]};
`else
  assign add_in2 = b_q;
`endif

  fp_adder u_add (.in1(a_q), .in2(add_in2), .out(add_out));

  assign idle       = (state_q == IDLE) & ~rst;
  assign grant      = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign req0_ready = idle & req0_valid & ~grant;
  assign req1_ready = idle & req1_valid & grant;
  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) & owner_q;
  assign rsp0_data  = rsp0_valid ? res_q : 32'd0;
  assign rsp1_data  = rsp1_valid ? res_q : 32'd0;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef FP_ADD_ARBITER_SUB_EN
    op_d    = op_q;
`endif
    case (state_q)
      IDLE: if (req0_valid | req1_valid) begin
        a_d     = grant ? req1_a : req0_a;
        b_d     = grant ? req1_b : req0_b;
`ifdef FP_ADD_ARBITER_SUB_EN
        op_d    = grant ? req1_op : req0_op;
`endif
        owner_d = grant;
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        state_d = WAIT;
      end
      // Adder output is only trusted once the operands have been held SETTLE_CYCLES.
      WAIT: if (cnt_q == 4'd0) begin
        res_d   = add_out;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (owner_q ? rsp1_ready : rsp0_ready) begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
`ifdef FP_ADD_ARBITER_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef FP_ADD_ARBITER_SUB_EN
      op_q    <= op_d;
`endif
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed and random traffic against a real-arithmetic reference.
module tb_fp_add_arbiter;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        busy;
`ifdef FP_ADD_ARBITER_SUB_EN
  logic        req0_op, req1_op;
`endif

  always #5 clk = ~clk;

  fp_add_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
`ifdef FP_ADD_ARBITER_SUB_EN
    .req0_op(req0_op), .req1_op(req1_op),
`endif
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] b; logic op;} op_t;

  op_t         q0[$], q1[$];
  int          grants[$];
  logic [31:0] resp_log[$];
  int          checks = 0, errors = 0;
  logic        m_prio;
  bit          outst;
  int          own, acc_cyc;
  logic [31:0] exp_d;
  int          fair_exp[4] = '{0, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] ref_add(input op_t x);
    return x.op ? r2f(f2r(x.a) - f2r(x.b)) : r2f(f2r(x.a) + f2r(x.b));
  endfunction

  // Short mantissas over a narrow exponent band keep every sum exact in single precision.
  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    logic [7:0] m;
    e = 8'(124 + $urandom_range(0, 7));
    m = 8'($urandom);
    return {1'($urandom), e, m, 15'b0};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a = rand_fp();
    o.b = rand_fp();
`ifdef FP_ADD_ARBITER_SUB_EN
    o.op = 1'($urandom);
`else
    o.op = 1'b0;
`endif
    return o;
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic op);
    op_t o;
    o.a = a; o.b = b; o.op = op;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    step();
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp1_data", rsp1_data, 32'd0);
    m_prio = 1'b0;
    outst  = 1'b0;
  endtask

  // Drives both queues cycle by cycle and checks every output against the arbitration rules.
  task automatic run(input int hold, input int stop_at);
    int cyc = 0;
    int hl  = hold;
    int eg;
    bit vis;
    while ((q0.size() > 0 || q1.size() > 0 || outst) && cyc < 200 && (stop_at < 0 || cyc < stop_at)) begin
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      req0_a = req0_valid ? q0[0].a : $urandom;
      req0_b = req0_valid ? q0[0].b : $urandom;
      req1_a = req1_valid ? q1[0].a : $urandom;
      req1_b = req1_valid ? q1[0].b : $urandom;
`ifdef FP_ADD_ARBITER_SUB_EN
      req0_op = req0_valid ? q0[0].op : 1'($urandom);
      req1_op = req1_valid ? q1[0].op : 1'($urandom);
`endif
      vis = outst && (cyc - acc_cyc) >= S + 1;
      rsp0_ready = (outst && own == 0) ? (vis && hl == 0) : 1'($urandom);
      rsp1_ready = (outst && own == 1) ? (vis && hl == 0) : 1'($urandom);
      #1;
      chk("busy", busy, outst);
      if (!outst) begin
        if (req0_valid && req1_valid) eg = int'(m_prio);
        else if (req0_valid)          eg = 0;
        else if (req1_valid)          eg = 1;
        else                          eg = -1;
        chk("req0_ready", req0_ready, eg == 0);
        chk("req1_ready", req1_ready, eg == 1);
        chk("rsp0_valid_idle", rsp0_valid, 1'b0);
        chk("rsp1_valid_idle", rsp1_valid, 1'b0);
        if (eg >= 0) begin
          own     = eg;
          exp_d   = (eg == 0) ? ref_add(q0[0]) : ref_add(q1[0]);
          if (eg == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          acc_cyc = cyc;
          outst   = 1'b1;
          hl      = hold;
          grants.push_back(eg);
        end
      end else begin
        chk("req0_ready_busy", req0_ready, 1'b0);
        chk("req1_ready_busy", req1_ready, 1'b0);
        chk("rsp0_valid", rsp0_valid, vis && own == 0);
        chk("rsp1_valid", rsp1_valid, vis && own == 1);
        chk("rsp0_data", rsp0_data, (vis && own == 0) ? exp_d : 32'd0);
        chk("rsp1_data", rsp1_data, (vis && own == 1) ? exp_d : 32'd0);
        if (vis) begin
          if (hl == 0) begin
            resp_log.push_back(own == 1 ? rsp1_data : rsp0_data);
            outst  = 1'b0;
            m_prio = (own == 0);
          end else begin
            hl--;
          end
        end
      end
      step();
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (stop_at < 0) chk("run_timeout", cyc < 200, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
`ifdef FP_ADD_ARBITER_SUB_EN
    req0_op = 1'b0; req1_op = 1'b0;
`endif
    step();
    do_reset();

    // Single operation on requester 0.
    q0.push_back(mk(32'h3F800000, 32'h40000000, 1'b0));
    run(0, -1);
    chk("single_data", resp_log[0], 32'h40400000);

    // Contention straight after reset: requester 0 first.
    do_reset();
    grants.delete(); resp_log.delete();
    q0.push_back(mk(32'h3F000000, 32'h3E800000, 1'b0));
    q1.push_back(mk(32'h3F800000, 32'h40000000, 1'b0));
    run(0, -1);
    chk("cont_grant0", grants[0], 0);
    chk("cont_grant1", grants[1], 1);
    chk("cont_data0", resp_log[0], 32'h3F400000);
    chk("cont_data1", resp_log[1], 32'h40400000);

    // Fairness with both requesters continuously valid.
    grants.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run(0, -1);
    for (int i = 0; i < 4; i++) chk("fair_grant", grants[i], fair_exp[i]);

    // Backpressure: response held for 5 cycles while the other side waits.
    q0.push_back(rand_op());
    q1.push_back(rand_op());
    run(5, -1);

    // Randomized traffic with random response stalls.
    for (int it = 0; it < 8; it++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) q0.push_back(rand_op());
      for (int k = $urandom_range(0, 3); k > 0; k--) q1.push_back(rand_op());
      run($urandom_range(0, 3), -1);
    end

    // Reset in the middle of WAIT, then normal operation.
    q0.push_back(rand_op());
    run(0, 2);
    chk("mid_wait_busy", busy, 1'b1);
    q0.delete(); q1.delete();
    do_reset();
    for (int i = 0; i < S + 2; i++) begin
      step();
      chk("post_rst_rsp0", rsp0_valid, 1'b0);
      chk("post_rst_rsp1", rsp1_valid, 1'b0);
    end
    q1.push_back(rand_op());
    run(0, -1);

`ifdef FP_ADD_ARBITER_SUB_EN
    resp_log.delete();
    q1.push_back(mk(32'h40400000, 32'h3F800000, 1'b1));
    q1.push_back(mk(32'h40400000, 32'h3F800000, 1'b0));
    run(1, -1);
    chk("sub_data", resp_log[0], 32'h40000000);
    chk("add_data", resp_log[1], 32'h40800000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
